// File: rtl/pipe_subtractor_v_pkg.sv
// Shared defaults and elaboration helpers for the pipelined subtractor.
// The chunk width is derived here so every file splits the word identically.
package pipe_subtractor_v_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_S = 4;

  function automatic int chunk_width(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit split_ok(input int w, input int s);
    return (s > 0) && (w % s == 0);
  endfunction

endpackage

// File: rtl/pipe_subtractor_v_sub.sv
// Combinational C-bit chunk subtract with borrow in/out.
// Borrow out is the sign bit of the (C+1)-bit zero-extended difference.
module simple_subtractor_v
  import pipe_subtractor_v_pkg::*;
#(
  parameter int C = chunk_width(DEF_W, DEF_S)
) (
  input  logic         b_in,
  input  logic [C-1:0] x_0,
  input  logic [C-1:0] x_1,
  output logic [C-1:0] y,
  output logic         b_out
);

  logic [C:0] diff_w;

  assign diff_w     = {1'b0, x_0} - {1'b0, x_1} - {{C{1'b0}}, b_in};
  assign {b_out, y} = diff_w;

endmodule

// File: rtl/pipe_subtractor_v.sv
// W-bit subtractor with borrow, split into S chunks, one chunk per pipeline stage.
// Level 0 registers the operands; level k+1 holds the result of chunk k.
module pipe_subtractor_v
  import pipe_subtractor_v_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int S = DEF_S
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         b_in,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         b_out
);

  localparam int C = chunk_width(W, S);

  if (!split_ok(W, S)) begin : g_bad_split
    $error("pipe_subtractor_v: W must be a non-zero multiple of S");
  end

  logic         en;
  logic         vld_q [0:S];
  logic         brw_q [0:S];
  // Low chunks hold finished differences, high chunks the unused minuend.
  logic [W-1:0] acc_q [0:S];
  logic [W-1:0] sub_q [0:S-1];

  assign en        = !vld_q[S] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[S];
  assign y         = acc_q[S];
  assign b_out     = brw_q[S];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q[0] <= 1'b0;
      brw_q[0] <= 1'b0;
      acc_q[0] <= '0;
      sub_q[0] <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      brw_q[0] <= b_in;
      acc_q[0] <= x_0;
      sub_q[0] <= x_1;
    end
  end

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    logic [C-1:0] diff_d;
    logic         bo_d;
    logic [W-1:0] acc_d;

    simple_subtractor_v #(.C(C)) u_sub (
      .b_in (brw_q[gi]),
      .x_0  (acc_q[gi][gi*C +: C]),
      .x_1  (sub_q[gi][gi*C +: C]),
      .y    (diff_d),
      .b_out(bo_d)
    );

    always_comb begin
      acc_d              = acc_q[gi];
      acc_d[gi*C +: C]   = diff_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[gi+1] <= 1'b0;
        brw_q[gi+1] <= 1'b0;
        acc_q[gi+1] <= '0;
      end else if (en) begin
        vld_q[gi+1] <= vld_q[gi];
        brw_q[gi+1] <= bo_d;
        acc_q[gi+1] <= acc_d;
      end
    end

    // The subtrahend is only needed up to the last stage.
    if (gi < S - 1) begin : g_skew
      always_ff @(posedge clk) begin
        if (rst) begin
          sub_q[gi+1] <= '0;
        end else if (en) begin
          sub_q[gi+1] <= sub_q[gi];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_subtractor_v.sv
// Bench for pipe_subtractor_v: directed table with latency checks, stall and reset
// sequences, then random traffic scored against an arithmetic reference model.
module tb_pipe_subtractor_v;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         b_in;
  logic [W-1:0] x_0;
  logic [W-1:0] x_1;
  logic         out_ready;
  logic         in_ready, out_valid, b_out;
  logic [W-1:0] y;
  logic         out_ready1;
  logic         in_ready1, out_valid1, b_out1;
  logic [W-1:0] y1;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  logic [W:0] exp_q [$];
  logic [W:0] exp_q1 [$];

  pipe_subtractor_v #(.W(W), .S(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
    .x_0(x_0), .x_1(x_1), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .b_out(b_out)
  );

  pipe_subtractor_v #(.W(W), .S(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .b_in(b_in),
    .x_0(x_0), .x_1(x_1), .out_valid(out_valid1), .out_ready(out_ready1),
    .y(y1), .b_out(b_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] s,
                                         input logic c);
    longint unsigned ua, us;
    logic [W-1:0]    d;
    ua = a;
    us = s;
    d  = a - s - W'(c);
    return {ua < us + c, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the S=4 instance, sampled mid-cycle.
  initial begin
    logic         hold_pending;
    logic [W-1:0] hold_y;
    logic         hold_b;
    logic [W:0]   e;
    hold_pending = 1'b0;
    hold_y = '0;
    hold_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_y", 64'(y), 64'(hold_y));
          chk("hold_b", 64'(b_out), 64'(hold_b));
        end
        chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stale_out: got y=%0h with no pending op, expected none", y);
          end else begin
            e = exp_q.pop_front();
            chk("sb_y", 64'(y), 64'(e[W-1:0]));
            chk("sb_b", 64'(b_out), 64'(e[W]));
            n_out++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_sub(x_0, x_1, b_in));
        hold_pending = out_valid && !out_ready;
        hold_y       = y;
        hold_b       = b_out;
      end
    end
  end

  // Scoreboard for the S=1 instance.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q1.delete();
      end else begin
        if (out_valid1 && out_ready1) begin
          if (exp_q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stale_out_s1: got y=%0h with no pending op, expected none", y1);
          end else begin
            e = exp_q1.pop_front();
            chk("sb1_y", 64'(y1), 64'(e[W-1:0]));
            chk("sb1_b", 64'(b_out1), 64'(e[W]));
          end
        end
        if (in_valid && in_ready1) exp_q1.push_back(ref_sub(x_0, x_1, b_in));
      end
    end
  end

  typedef struct {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic         bin;
    logic [W-1:0] ey;
    logic         eb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int           n0;
    int           r;
    logic [W-1:0] ops [4];

    tbl[0] = '{32'd5,         32'd3,         1'b0, 32'd2,         1'b0};
    tbl[1] = '{32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[2] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0};
    tbl[3] = '{32'h10,        32'h10,        1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'd0,         1'b1, 32'hFFFF_FFFE, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1,         1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{32'h0100_0000, 32'd1,         1'b0, 32'h00FF_FFFF, 1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    b_in       = 1'b0;
    x_0        = '0;
    x_1        = '0;
    out_ready  = 1'b1;
    out_ready1 = 1'b1;

    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_b_out", 64'(b_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_s1_out_valid", 64'(out_valid1), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors, one at a time, with exact latency.
    for (int i = 0; i < 8; i++) begin
      x_0      = tbl[i].x0;
      x_1      = tbl[i].x1;
      b_in     = tbl[i].bin;
      in_valid = 1'b1;
      chk("tbl_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("tbl_lat0", 64'(out_valid), 64'd0);
      for (int k = 1; k <= 4; k++) begin
        tick();
        chk("tbl_lat", 64'(out_valid), 64'(k == 4));
        if (k == 1) begin
          chk("tbl_s1_valid", 64'(out_valid1), 64'd1);
          chk("tbl_s1_y", 64'(y1), 64'(tbl[i].ey));
          chk("tbl_s1_b", 64'(b_out1), 64'(tbl[i].eb));
        end
        if (k == 4) begin
          chk("tbl_y", 64'(y), 64'(tbl[i].ey));
          chk("tbl_b", 64'(b_out), 64'(tbl[i].eb));
        end
      end
    end
    tick();

    // Four back-to-back operations, then a three-cycle output stall.
    ops[0] = 32'd100;
    ops[1] = 32'h0001_0000;
    ops[2] = 32'd0;
    ops[3] = 32'hDEAD_BEEF;
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      x_0      = ops[i];
      x_1      = 32'd7 + 32'(i);
      b_in     = i[0];
      in_valid = 1'b1;
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    repeat (8) tick();
    chk("b2b_delivered", 64'(n_out - n0), 64'd4);
    chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      x_0      = 32'h1234_0000 + 32'(i);
      x_1      = 32'h0000_5678;
      b_in     = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_y", 64'(y), 64'd0);
    chk("midrst_s1_valid", 64'(out_valid1), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic with stalls and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      r        = int'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      b_in     = $urandom_range(0, 1) == 1;
      case (r)
        0: begin x_0 = $urandom; x_1 = $urandom; end
        1: begin x_0 = $urandom_range(0, 3); x_1 = $urandom_range(0, 3); end
        2: begin x_0 = $urandom; x_1 = x_0; end
        default: begin
          x_0 = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0;
          x_1 = $urandom;
        end
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = (!rst) && ($urandom_range(0, 99) == 0);
      tick();
    end

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_main", 64'(exp_q.size()), 64'd0);
    chk("drain_s1", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
